store_buffer: RTL

//  Write-side counterpart of the load writeback path. Accepts SB/SH/SW stores from EX,

---
 rtl/store_buffer_pkg.sv | 18 +
 rtl/store_buffer_if.sv | 18 +
 rtl/store_buffer_align.sv | 38 +++
 rtl/store_buffer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: funct3 encodings,
// cache data bus width, entry payload and FSM states.
package store_buffer_pkg;
  localparam logic [2:0] INST_SB = 3'b000;
  localparam logic [2:0] INST_SH = 3'b001;
  localparam logic [2:0] INST_SW = 3'b010;

  localparam int          CACHE_DATA_W = 32;
  localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;

  typedef enum logic {S_IDLE, S_WRITE} sb_state_t;

  // Lane-aligned payload of one queued store.
  typedef struct packed {
    logic [CACHE_DATA_W-1:0] data;
    logic [3:0]              be;
  } sb_lane_t;
endpackage

// File: rtl/store_buffer_if.sv
// Cache write port: registered request from the store buffer, waitrequest
// back from the cache.
interface store_buffer_if #(parameter int AW = 32) ();
  logic          o_p_write;
  logic [AW-1:0] o_p_address;
  logic [31:0]   o_p_writedata;
  logic [3:0]    o_p_byteenable;
  logic          i_p_waitrequest;

  modport master (
    output o_p_write, o_p_address, o_p_writedata, o_p_byteenable,
    input  i_p_waitrequest
  );
  modport slave (
    input  o_p_write, o_p_address, o_p_writedata, o_p_byteenable,
    output i_p_waitrequest
  );
endinterface

// File: rtl/store_buffer_align.sv
// Store alignment: replicates store data across byte lanes and builds the
// byte enables from the low address bits. Unknown funct3 yields valid=0.
module store_align
  import store_buffer_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  output logic [31:0] data,
  output logic [3:0]  be,
  output logic        valid
);
  // Lane replication and enable generation per store width.
  always_comb begin
    data  = ZERO_WORD;
    be    = 4'b0000;
    valid = 1'b0;
    case (funct3)
      INST_SB: begin
        data  = {4{wdata[7:0]}};
        be    = 4'b0001 << offset;
        valid = 1'b1;
      end
      INST_SH: begin
        // Only offset 0 selects the low half, mirroring load-side extraction.
        data  = {2{wdata[15:0]}};
        be    = (offset == 2'b00) ? 4'b0011 : 4'b1100;
        valid = 1'b1;
      end
      INST_SW: begin
        data  = wdata;
        be    = 4'b1111;
        valid = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/store_buffer.sv
// Store buffer: aligns stores from EX, queues them in a DEPTH-entry FIFO and
// drains them in order to the cache with a write/waitrequest handshake.
// Flags loads whose word matches any queued or in-flight store.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_write_mem,
  input  logic [AW-1:0]      ex_addr,
  input  logic [31:0]        ex_wdata,
  input  logic [2:0]         ex_funct3,
  output logic               sb_full_o,
  output logic               sb_empty_o,
  store_buffer_if.master     cache,
  input  logic [AW-1:0]      ld_check_addr,
  output logic               ld_hazard_o
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-3:0]    waddr_q [DEPTH];
  sb_lane_t         lane_q  [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    rd_ptr, wr_ptr, rd_nxt;
  logic [PW:0]      count, count_next;
  sb_state_t        state, state_next;

  logic [31:0] al_data;
  logic [3:0]  al_be;
  logic        al_ok;
  logic        push, pop, load_head, load_nxt;
  logic [AW-1:0] ld_word;

  store_align u_align (
    .funct3 (ex_funct3),
    .offset (ex_addr[1:0]),
    .wdata  (ex_wdata),
    .data   (al_data),
    .be     (al_be),
    .valid  (al_ok)
  );

  // Full is the registered flag, so a same-cycle pop never admits a push.
  assign push    = ex_write_mem && !sb_full_o && al_ok;
  assign rd_nxt  = rd_ptr + PW'(1);
  assign ld_word = ld_check_addr >> 2;

  // Occupancy update from push/pop.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + (PW+1)'(1);
      2'b01:   count_next = count - (PW+1)'(1);
      default: ;
    endcase
  end

  // Entry storage; contents are qualified by valid_q so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      waddr_q[wr_ptr] <= ex_addr[AW-1:2];
      lane_q[wr_ptr]  <= '{data: al_data, be: al_be};
    end
  end

  // Pointers, valid bits, count and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      sb_full_o  <= 1'b0;
      sb_empty_o <= 1'b1;
    end else begin
      if (pop) begin
        valid_q[rd_ptr] <= 1'b0;
        rd_ptr          <= rd_nxt;
      end
      if (push) begin
        valid_q[wr_ptr] <= 1'b1;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      count      <= count_next;
      sb_full_o  <= (count_next == (PW+1)'(DEPTH));
      sb_empty_o <= (count_next == '0);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // FSM next state: issue head from IDLE, pop on accept, chain if more remain.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_head  = 1'b0;
    load_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          load_head  = 1'b1;
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!cache.i_p_waitrequest) begin
          pop = 1'b1;
          // Same-cycle push is not considered; count excludes it here.
          if (count > (PW+1)'(1)) load_nxt   = 1'b1;
          else                    state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Registered cache request; held stable while waitrequest is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache.o_p_write      <= 1'b0;
      cache.o_p_address    <= '0;
      cache.o_p_writedata  <= ZERO_WORD;
      cache.o_p_byteenable <= 4'b0000;
    end else if (load_head) begin
      cache.o_p_write      <= 1'b1;
      cache.o_p_address    <= {waddr_q[rd_ptr], 2'b00};
      cache.o_p_writedata  <= lane_q[rd_ptr].data;
      cache.o_p_byteenable <= lane_q[rd_ptr].be;
    end else if (load_nxt) begin
      cache.o_p_write      <= 1'b1;
      cache.o_p_address    <= {waddr_q[rd_nxt], 2'b00};
      cache.o_p_writedata  <= lane_q[rd_nxt].data;
      cache.o_p_byteenable <= lane_q[rd_nxt].be;
    end else if (pop) begin
      cache.o_p_write      <= 1'b0;
    end
  end

  // Word-granular match against every valid entry, in-flight head included.
  always_comb begin
    ld_hazard_o = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (valid_q[i] && ({2'b00, waddr_q[i]} == ld_word)) ld_hazard_o = 1'b1;
  end
endmodule
